// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, A, B,
                    input  busy, done, div_by_zero, hi, lo);
    modport slave  (input  start, op, A, B,
                    output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shift-add /
// restoring-subtract step per cycle on a shared 2*WIDTH accumulator.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;

    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && !bus.op[2]) state_next = CALC;
            CALC:    if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // op[0]=0 selects the signed variants of both MULT and DIV.
    always_comb begin
        a_neg = bus.A[WIDTH-1] & ~bus.op[0];
        b_neg = bus.B[WIDTH-1] & ~bus.op[0];
        mag_a = a_neg ? -bus.A : bus.A;
        mag_b = b_neg ? -bus.B : bus.B;
    end

    // Divide shifts {rem,quot} left and trial-subtracts; multiply adds into the top half and shifts right.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, operand};
        acc_step  = acc;
        if (is_div) begin
            if (!div_diff[WIDTH])
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_step = {mul_sum, acc[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        product   = neg_main ? -acc : acc;
        quotient  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            operand  <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.op[2]) begin
                        count    <= CW'(WIDTH - 1);
                        is_div   <= bus.op[1];
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        b_zero   <= (bus.B == '0);
                        if (bus.op[1]) begin
                            acc     <= {{WIDTH{1'b0}}, mag_a};
                            operand <= mag_b;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, mag_b};
                            operand <= mag_a;
                        end
                    end else if (bus.start && !bus.op[1]) begin
                        if (bus.op[0]) lo_q <= bus.A;
                        else           hi_q <= bus.A;
                        done_q <= 1'b1;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count - 1'b1;
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (is_div) begin
                        // A zero divisor leaves the dividend magnitude as remainder, so hi already equals A.
                        hi_q  <= remainder;
                        lo_q  <= b_zero ? {WIDTH{1'b1}} : quotient;
                        dbz_q <= b_zero;
                    end else begin
                        hi_q <= product[2*WIDTH-1:WIDTH];
                        lo_q <= product[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
    localparam int WIDTH = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Pulses start for exactly one rising edge; returns 1ns after that edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (1) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_cnt++;
            if (edges >= 200) begin
                checkOutput("done_timeout", 64'(edges), 64'd33);
                break;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
        int edges;
        int busy_cnt;
        applyStimulus(op, a, b);
        waitDone(edges, busy_cnt);
        checkOutput({tag, "_latency"}, 64'(edges), 64'd33);
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        checkOutput({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int edges;
        int busy_cnt;
        int done_seen;
        int busy_seen;
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        runOp("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        runOp("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        runOp("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runOp("divu",      OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
        runOp("div_wrap",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        runOp("divu_zero", OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        runOp("div_zero",  OP_DIV,   32'hFFFFFF00, 32'h00000000, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1);

        // MTHI issued mid-multiply must be dropped.
        applyStimulus(OP_MULT, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'h0);
        waitDone(edges, busy_cnt);
        checkOutput("busy_mthi_hi", 64'(bus.hi), 64'h0);
        checkOutput("busy_mthi_lo", 64'(bus.lo), 64'h1E);
        @(posedge clk);
        #1;

        applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'h0);
        checkOutput("mthi_done", 64'(bus.done), 64'd1);
        checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi_hi", 64'(bus.hi), 64'hDEADBEEF);
        checkOutput("mthi_lo", 64'(bus.lo), 64'h1E);
        @(posedge clk);
        #1;
        checkOutput("mthi_done_pulse", 64'(bus.done), 64'd0);
        checkOutput("mthi_busy_after", 64'(bus.busy), 64'd0);

        applyStimulus(OP_MTLO, 32'h13579BDF, 32'h0);
        checkOutput("mtlo_done", 64'(bus.done), 64'd1);
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h13579BDF);
        checkOutput("mtlo_hi", 64'(bus.hi), 64'hDEADBEEF);

        applyStimulus(OP_RSVD, 32'hCAFEF00D, 32'h1);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done === 1'b1) done_seen++;
            if (bus.busy === 1'b1) busy_seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("rsvd_done", 64'(done_seen), 64'd0);
        checkOutput("rsvd_busy", 64'(busy_seen), 64'd0);
        checkOutput("rsvd_hi", 64'(bus.hi), 64'hDEADBEEF);
        checkOutput("rsvd_lo", 64'(bus.lo), 64'h13579BDF);

        // Reset in the middle of CALC discards the operation entirely.
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midop_busy_before", 64'(bus.busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midop_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("midop_rst_hi", 64'(bus.hi), 64'd0);
        checkOutput("midop_rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
        end
        checkOutput("midop_no_done", 64'(done_seen), 64'd0);

        runOp("divu_after_rst", OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide sequencer beside the ALU in the execute stage.
- Executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Raises busy so the hazard unit can stall MFHI/MFLO and any further mult/div issue until the result is written.
- One shared shift-add / restoring-subtract datapath, sequenced by a small FSM.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- start  input  1  issue request, sampled on rising clk; honoured only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- busy  output  1  high while a multi-cycle op is in flight.
- done  output  1  one-cycle pulse; HI/LO are updated in the same cycle.
- div_by_zero  output  1  valid with done; high iff the completed op was DIV/DIVU with B==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low at a rising edge, from any state, including mid-operation):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Iteration counter is cleared; any in-flight result is discarded and no done is produced.
- States: IDLE, CALC, FIX.
- IDLE, start=1 with op in {000..011}:
  - Latch the operand magnitudes (absolute value for signed ops, raw for unsigned), the result signs and the op.
  - Counter=WIDTH-1; go to CALC; busy=1 from the next cycle.
- IDLE, start=1 with op=100 or 101:
  - hi<=A (MTHI) or lo<=A (MTLO) at that edge; the other register is unchanged.
  - done=1 for the following cycle only; busy stays 0; div_by_zero=0.
- IDLE, start=1 with op=110/111: ignored; no state change, no done.
- CALC:
  - One iteration per edge for WIDTH edges; counter decrements; after the iteration at counter==0, go to FIX.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring division producing a WIDTH-bit quotient and remainder.
- FIX, single edge:
  - Apply sign correction. MULT product is negated if the operand signs differ. DIV quotient truncates toward zero; the remainder takes the dividend's sign.
  - Write {hi,lo}=product, or hi=remainder and lo=quotient.
  - done=1 and busy=0 in the following cycle; return to IDLE.
- Latency:
  - If start is sampled at edge E0, then HI/LO are written and done is high in the cycle after edge E(WIDTH+1).
  - For WIDTH=32 that is 33 edges after the start edge.
  - busy is high for exactly WIDTH+1 cycles.
- start while busy: ignored completely; operands are not re-latched. The issuer must hold the op until busy is low.
- hi/lo hold their previous values throughout CALC; there are no partial results.
- Divide by zero (either signedness):
  - Full latency is still consumed.
  - FIX forces hi=A (original dividend) and lo={WIDTH{1'b1}}, with div_by_zero=1 alongside done.
- DIV with most-negative dividend and B=-1: lo=most-negative value, hi=0 (wraps, no trap).
- A new start is accepted in the same cycle that done is high (state is already IDLE).
- done is a registered, single-cycle pulse and is never held high across two consecutive cycles by one op.
- All outputs are registered; there is no combinational path from the inputs to any output.

Test Plan:
- MULTU A=FFFFFFFF B=FFFFFFFF -> busy for 33 cycles; done pulse 33 edges after start; hi=FFFFFFFE, lo=00000001.
- MULT A=FFFFFFFE B=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA. Then MULT A=80000000 B=80000000 -> hi=40000000, lo=00000000.
- DIV A=FFFFFFF9 B=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU A=00000007 B=00000002 -> lo=00000003, hi=00000001.
- DIV A=80000000 B=FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0. DIVU A=12345678 B=0 -> hi=12345678, lo=FFFFFFFF, div_by_zero=1.
- MTHI A=DEADBEEF issued during a busy MULT -> ignored, hi unchanged at completion. Re-issue after done -> hi=DEADBEEF next cycle, done for 1 cycle, busy never high, lo unchanged.
- Reset after 10 CALC cycles of a MULTU -> next cycle busy=0, hi=lo=0, no done ever. A following DIVU A=64 B=7 completes normally with lo=0000000E, hi=00000002.
